// File: rtl/adder_result_collector_pkg.sv
// Shared types for the adder result collector: nibble width, result record
// and the output-stage state encoding.
package adder_result_collector_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic ST_EMPTY_ENC = 1'b0;
    localparam logic ST_FULL_ENC  = 1'b1;

    typedef struct packed {
        logic                carry;
        logic [NIBBLE_W-1:0] sum;
    } result_t;

    typedef enum logic {
        ST_EMPTY = ST_EMPTY_ENC,
        ST_FULL  = ST_FULL_ENC
    } out_state_e;

endpackage

// File: rtl/adder_result_collector_if.sv
// Upstream result handshake, flush and downstream frame handshake bundled
// into one interface; slave is the collector's view, master the driver's.
interface adder_result_collector_if
    import adder_result_collector_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int CNT_W   = 8
);
    logic                               in_valid;
    logic                               in_ready;
    logic [NIBBLE_W-1:0]                in_sum;
    logic                               in_carry;
    logic                               flush;
    logic                               out_valid;
    logic                               out_ready;
    logic [NIBBLE_W*NIBBLES-1:0]        out_data;
    logic [NIBBLES-1:0]                 out_carry;
    logic [$clog2(NIBBLES+1)-1:0]       out_count;
    logic [CNT_W-1:0]                   ovf_count;

    modport slave (
        input  in_valid, in_sum, in_carry, flush, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_count, ovf_count
    );

    modport master (
        output in_valid, in_sum, in_carry, flush, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_count, ovf_count
    );

endinterface

// File: rtl/adder_result_collector_nibble_packer.sv
// Collect register: packs accepted results slot by slot, closes a frame when
// full or flushed, and holds a closed frame until the output stage is free.
module adder_result_collector_nibble_packer
    import adder_result_collector_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    i_valid,
    input  logic [NIBBLE_W-1:0]                     i_sum,
    input  logic                                    i_carry,
    input  logic                                    i_flush,
    input  logic                                    i_out_free,
    output logic                                    o_ready,
    output logic                                    o_accept,
    output logic                                    o_load,
    output logic [NIBBLE_W*NIBBLES-1:0]             o_data,
    output logic [NIBBLES-1:0]                      o_carry,
    output logic [$clog2(NIBBLES+1)-1:0]            o_count
);
    localparam int DW = NIBBLE_W * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);

    logic [DW-1:0]      r_data;
    logic [NIBBLES-1:0] r_carry;
    logic [CW-1:0]      r_idx;
    logic               r_held;

    result_t            w_res;
    logic               w_accept;
    logic               w_close_new;
    logic               w_load;
    logic [CW-1:0]      w_cnt_after;
    logic [DW-1:0]      w_data_m;
    logic [DW-1:0]      w_data_s0;
    logic [NIBBLES-1:0] w_carry_m;
    logic [NIBBLES-1:0] w_carry_s0;

    assign w_res       = '{carry: i_carry, sum: i_sum};
    assign o_ready     = !r_held || i_out_free;
    assign w_accept    = i_valid && o_ready;
    assign w_cnt_after = r_idx + CW'(w_accept);
    // A held frame is already closed, so flush is ignored while holding.
    assign w_close_new = !r_held &&
                         ((w_accept && (r_idx == CW'(NIBBLES - 1))) ||
                          (i_flush && (w_cnt_after != '0)));
    assign w_load      = (r_held || w_close_new) && i_out_free;

    always_comb begin
        w_data_m   = r_data;
        w_carry_m  = r_carry;
        w_data_s0  = '0;
        w_carry_s0 = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (w_accept && (r_idx == CW'(i))) begin
                w_data_m[NIBBLE_W*i +: NIBBLE_W] = w_res.sum;
                w_carry_m[i]                     = w_res.carry;
            end
        end
        w_data_s0[NIBBLE_W-1:0] = w_res.sum;
        w_carry_s0[0]           = w_res.carry;
    end

    assign o_accept = w_accept;
    assign o_load   = w_load;
    assign o_data   = r_held ? r_data  : w_data_m;
    assign o_carry  = r_held ? r_carry : w_carry_m;
    assign o_count  = r_held ? r_idx   : w_cnt_after;

    // On a held-frame drain the nibble accepted that cycle starts the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_carry <= '0;
            r_idx   <= '0;
            r_held  <= 1'b0;
        end else if (r_held) begin
            if (i_out_free) begin
                r_held  <= 1'b0;
                r_data  <= w_accept ? w_data_s0  : '0;
                r_carry <= w_accept ? w_carry_s0 : '0;
                r_idx   <= CW'(w_accept);
            end
        end else if (w_close_new && i_out_free) begin
            r_data  <= '0;
            r_carry <= '0;
            r_idx   <= '0;
        end else begin
            r_data  <= w_data_m;
            r_carry <= w_carry_m;
            r_idx   <= w_cnt_after;
            r_held  <= w_close_new;
        end
    end

endmodule

// File: rtl/adder_result_collector.sv
// Collects four_bit_adder results into frames; output register with an
// EMPTY/FULL valid/ready stage and a saturating overflow counter.
module adder_result_collector
    import adder_result_collector_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    adder_result_collector_if.slave   bus
);
    localparam int DW = NIBBLE_W * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);

    out_state_e         r_state;
    out_state_e         w_state_next;
    logic [DW-1:0]      r_out_data;
    logic [NIBBLES-1:0] r_out_carry;
    logic [CW-1:0]      r_out_count;
    logic [CNT_W-1:0]   r_ovf;

    logic               w_out_free;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_load;
    logic [DW-1:0]      w_frame_data;
    logic [NIBBLES-1:0] w_frame_carry;
    logic [CW-1:0]      w_frame_count;

    adder_result_collector_nibble_packer #(
        .NIBBLES (NIBBLES)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (bus.in_valid),
        .i_sum      (bus.in_sum),
        .i_carry    (bus.in_carry),
        .i_flush    (bus.flush),
        .i_out_free (w_out_free),
        .o_ready    (bus.in_ready),
        .o_accept   (w_accept),
        .o_load     (w_load),
        .o_data     (w_frame_data),
        .o_carry    (w_frame_carry),
        .o_count    (w_frame_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A load while draining keeps the stage FULL with the new frame.
    always_comb begin
        w_state_next = r_state;
        w_out_valid  = (r_state == ST_FULL);
        w_out_free   = (r_state == ST_EMPTY) || bus.out_ready;
        if (w_load) begin
            w_state_next = ST_FULL;
        end else if (w_out_valid && bus.out_ready) begin
            w_state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_carry <= '0;
            r_out_count <= '0;
            r_ovf       <= '0;
        end else begin
            if (w_load) begin
                r_out_data  <= w_frame_data;
                r_out_carry <= w_frame_carry;
                r_out_count <= w_frame_count;
            end
            if (w_accept && bus.in_carry && (r_ovf != '1)) begin
                r_ovf <= r_ovf + 1'b1;
            end
        end
    end

    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_carry = r_out_carry;
    assign bus.out_count = r_out_count;
    assign bus.ovf_count = r_ovf;

endmodule

// File: tb/tb_adder_result_collector.sv
// Directed bench for adder_result_collector: framing, backpressure, flush,
// counter saturation (second instance with a 2-bit counter) and reset.
module tb_adder_result_collector;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    adder_result_collector_if #(.NIBBLES(4), .CNT_W(8)) bus ();
    adder_result_collector_if #(.NIBBLES(4), .CNT_W(2)) bus2 ();

    adder_result_collector #(.NIBBLES(4), .CNT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    adder_result_collector #(.NIBBLES(4), .CNT_W(2)) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] sum, input logic carry);
        bus.in_valid = 1'b1;
        bus.in_sum   = sum;
        bus.in_carry = carry;
        tick();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_sum   = 4'h0;
        bus.in_carry = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL rst_data got %h exp 0000", bus.out_data); end
        checks++; if (bus.out_carry !== 4'b0000) begin errors++; $display("FAIL rst_carry got %b exp 0000", bus.out_carry); end
        checks++; if (bus.out_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.out_count); end
        checks++; if (bus.ovf_count !== 8'd0) begin errors++; $display("FAIL rst_ovf got %0d exp 0", bus.ovf_count); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_full_frame();
        logic [3:0] sums[4];
        logic       cars[4];
        sums = '{4'hE, 4'h0, 4'h2, 4'h4};
        cars = '{1'b0, 1'b1, 1'b1, 1'b1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready[%0d] got %b exp 1", i, bus.in_ready); end
            send(sums[i], cars[i]);
        end
        idle();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h420E) begin errors++; $display("FAIL full_data got %h exp 420e", bus.out_data); end
        checks++; if (bus.out_carry !== 4'b1110) begin errors++; $display("FAIL full_carry got %b exp 1110", bus.out_carry); end
        checks++; if (bus.out_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", bus.out_count); end
        checks++; if (bus.ovf_count !== 8'd3) begin errors++; $display("FAIL full_ovf got %0d exp 3", bus.ovf_count); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_drained got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        send(4'hE, 1'b0);
        send(4'h0, 1'b1);
        send(4'h2, 1'b1);
        send(4'h4, 1'b1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", bus.out_valid); end
        for (int i = 0; i < 4; i++) send(4'h1, 1'b0);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_held got %b exp 0", bus.in_ready); end
        checks++; if (bus.out_data !== 16'h420E) begin errors++; $display("FAIL bp_stable_data got %h exp 420e", bus.out_data); end
        send(4'hF, 1'b1);
        idle();
        checks++; if (bus.ovf_count !== 8'd6) begin errors++; $display("FAIL bp_ovf_blocked got %0d exp 6", bus.ovf_count); end
        checks++; if (bus.out_data !== 16'h420E) begin errors++; $display("FAIL bp_stable_data2 got %h exp 420e", bus.out_data); end
        checks++; if (bus.out_carry !== 4'b1110) begin errors++; $display("FAIL bp_stable_carry got %b exp 1110", bus.out_carry); end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_comb got %b exp 1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h1111) begin errors++; $display("FAIL bp_second_data got %h exp 1111", bus.out_data); end
        checks++; if (bus.out_carry !== 4'b0000) begin errors++; $display("FAIL bp_second_carry got %b exp 0000", bus.out_carry); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after got %b exp 1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b1;
        send(4'hE, 1'b0);
        send(4'h0, 1'b1);
        idle();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h000E) begin errors++; $display("FAIL flush_data got %h exp 000e", bus.out_data); end
        checks++; if (bus.out_carry !== 4'b0010) begin errors++; $display("FAIL flush_carry got %b exp 0010", bus.out_carry); end
        checks++; if (bus.out_count !== 3'd2) begin errors++; $display("FAIL flush_count got %0d exp 2", bus.out_count); end
        send(4'h3, 1'b0);
        send(4'h5, 1'b0);
        send(4'h7, 1'b0);
        send(4'h9, 1'b0);
        checks++; if (bus.out_data !== 16'h9753) begin errors++; $display("FAIL flush_next_data got %h exp 9753", bus.out_data); end
        checks++; if (bus.out_count !== 3'd4) begin errors++; $display("FAIL flush_next_count got %0d exp 4", bus.out_count); end
        bus.flush = 1'b1;
        send(4'hA, 1'b1);
        bus.flush = 1'b0;
        idle();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_acc_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h000A) begin errors++; $display("FAIL flush_acc_data got %h exp 000a", bus.out_data); end
        checks++; if (bus.out_carry !== 4'b0001) begin errors++; $display("FAIL flush_acc_carry got %b exp 0001", bus.out_carry); end
        checks++; if (bus.out_count !== 3'd1) begin errors++; $display("FAIL flush_acc_count got %0d exp 1", bus.out_count); end
        checks++; if (bus.ovf_count !== 8'd8) begin errors++; $display("FAIL flush_acc_ovf got %0d exp 8", bus.ovf_count); end
    endtask

    task automatic test_flush_empty();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fe_drained got %b exp 0", bus.out_valid); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fe_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.ovf_count !== 8'd8) begin errors++; $display("FAIL fe_ovf got %0d exp 8", bus.ovf_count); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_sat[5];
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_sum   = 4'(i);
            bus2.in_carry = 1'b1;
            tick();
            checks++; if (bus2.ovf_count !== exp_sat[i]) begin errors++; $display("FAIL sat_ovf[%0d] got %0d exp %0d", i, bus2.ovf_count, exp_sat[i]); end
        end
        bus2.in_valid = 1'b0;
        bus2.in_carry = 1'b0;
    endtask

    task automatic test_reset_midflight();
        bus.out_ready = 1'b0;
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        send(4'h4, 1'b0);
        checks++; if (bus.out_data !== 16'h4321) begin errors++; $display("FAIL mr_held_data got %h exp 4321", bus.out_data); end
        send(4'h5, 1'b1);
        send(4'h6, 1'b1);
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL mr_data got %h exp 0000", bus.out_data); end
        checks++; if (bus.out_carry !== 4'b0000) begin errors++; $display("FAIL mr_carry got %b exp 0000", bus.out_carry); end
        checks++; if (bus.out_count !== 3'd0) begin errors++; $display("FAIL mr_count got %0d exp 0", bus.out_count); end
        checks++; if (bus.ovf_count !== 8'd0) begin errors++; $display("FAIL mr_ovf got %0d exp 0", bus.ovf_count); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mr_in_ready got %b exp 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(4'h8, 1'b0);
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mr_partial_valid[%0d] got %b exp 0", i, bus.out_valid); end
        end
        send(4'h8, 1'b0);
        idle();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mr_new_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h8888) begin errors++; $display("FAIL mr_new_data got %h exp 8888", bus.out_data); end
        checks++; if (bus.out_count !== 3'd4) begin errors++; $display("FAIL mr_new_count got %0d exp 4", bus.out_count); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_sum     = 4'h0;
        bus.in_carry   = 1'b0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_sum    = 4'h0;
        bus2.in_carry  = 1'b0;
        bus2.flush     = 1'b0;
        bus2.out_ready = 1'b1;

        test_reset();
        test_full_frame();
        test_backpressure();
        test_flush();
        test_flush_empty();
        test_saturate();
        test_reset_midflight();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
